// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run/step/halt controller: FSM state encoding and
// the halt-cause codes reported on halt_cause.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_CPU    = 2'd1;
  localparam logic [1:0] CAUSE_BP     = 2'd2;
  localparam logic [1:0] CAUSE_BUDGET = 2'd3;

  // States in which the core is clocked forward.
  function automatic logic is_enabled(input state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_run_cnt.sv
// Saturating executed-cycle counter with synchronous clear; clear wins over
// increment and the count sticks at all-ones.
module cpu_run_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer driving the MIPS core enable. Optional breakpoint
// comparator is built only when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             cpu_halt,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  input  logic [CNT_W-1:0] max_cycles,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             halted,
  output logic [1:0]       halt_cause
);

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       en_q;
  logic       halted_q;
  logic       cnt_clr;
  logic       bp_hit;
  logic       budget_hit;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  // Break-after: the matching instruction executes in this cycle, then halt.
  assign bp_hit = bp_valid && (pc == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
  assign bp_hit    = 1'b0;
`endif

  // Wrapped sum never equals a nonzero budget once saturated or past it.
  assign budget_hit = (max_cycles != '0) && ((cycle_cnt + CNT_W'(1)) == max_cycles);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end else if (step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cpu_halt) begin
          state_d = ST_HALT;
          cause_d = CAUSE_CPU;
        end else if (bp_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_BP;
        end else if (budget_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_BUDGET;
        end
      end
      ST_STEP: begin
        if (cpu_halt) begin
          state_d = ST_HALT;
          cause_d = CAUSE_CPU;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (stop) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
        end else if (start) begin
          state_d = ST_RUN;
          cause_d = CAUSE_NONE;
        end else if (step) begin
          state_d = ST_STEP;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  // Outputs are registered from the next state so they come straight off flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cause_q  <= CAUSE_NONE;
      en_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      en_q     <= is_enabled(state_d);
      halted_q <= (state_d == ST_HALT);
    end
  end

  cpu_run_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (en_q),
    .cnt   (cycle_cnt)
  );

  assign cpu_en     = en_q;
  assign state      = state_q;
  assign halted     = halted_q;
  assign halt_cause = cause_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: vector table for the main run/step/halt
// flow plus hand-written sequences for reset, stepping and breakpoints.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, step, cpu_halt;
  logic [31:0] pc, bp_addr, max_cycles;
  logic        bp_valid;
  logic        cpu_en, halted;
  logic [1:0]  state, halt_cause;
  logic [31:0] cycle_cnt;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.CNT_W(32), .PC_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .cpu_halt   (cpu_halt),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .bp_valid   (bp_valid),
    .max_cycles (max_cycles),
    .cpu_en     (cpu_en),
    .state      (state),
    .cycle_cnt  (cycle_cnt),
    .halted     (halted),
    .halt_cause (halt_cause)
  );

  typedef struct {
    logic        start, stop, step, cpu_halt;
    logic [1:0]  st;
    logic        en;
    logic [31:0] cnt;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic a, input logic b, input logic c, input logic d,
                              input logic [1:0] st, input logic en,
                              input logic [31:0] cnt, input logic [1:0] cause);
    vec_t v;
    v.start = a; v.stop = b; v.step = c; v.cpu_halt = d;
    v.st = st; v.en = en; v.cnt = cnt; v.cause = cause;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic en,
                           input logic [31:0] cnt, input logic [1:0] cause);
    check({tag, ".state"},  64'(state),      64'(st));
    check({tag, ".cpu_en"}, 64'(cpu_en),     64'(en));
    check({tag, ".cnt"},    64'(cycle_cnt),  64'(cnt));
    check({tag, ".cause"},  64'(halt_cause), 64'(cause));
    check({tag, ".halted"}, 64'(halted),     64'(st == 2'd3));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start = 1'b0; stop = 1'b0; step = 1'b0; cpu_halt = 1'b0;
  endtask

  initial begin
    // start stop step halt | state en cnt cause
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd0,  2'd0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd1,  2'd0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd2,  2'd0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd3,  2'd0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd4,  2'd0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'd5,  2'd3);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'd5,  2'd3);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd5,  2'd0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd6,  2'd0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd7,  2'd0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd8,  2'd0);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'd8,  2'd0);
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'd9,  2'd0);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'd9,  2'd0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd10, 2'd0);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd0,  2'd0);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'd1,  2'd0);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd0,  2'd0);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 32'd1,  2'd1);
    vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'd1,  2'd0);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 32'd2,  2'd1);
    vecs[21] = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd2,  2'd0);

    reset = 1'b1;
    idle_inputs();
    pc = 32'd0; bp_addr = 32'd0; bp_valid = 1'b0; max_cycles = 32'd5;
    tick(); tick();
    check_all("reset", 2'd0, 1'b0, 32'd0, 2'd0);
    reset = 1'b0;
    tick();
    check_all("post_reset", 2'd0, 1'b0, 32'd0, 2'd0);

    for (int i = 0; i < 22; i++) begin
      start = vecs[i].start; stop = vecs[i].stop;
      step = vecs[i].step;   cpu_halt = vecs[i].cpu_halt;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].cnt, vecs[i].cause);
    end
    idle_inputs();

    // Reset asserted between edges while running.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check_all("pre_abort", 2'd1, 1'b1, 32'd1, 2'd0);
    #2 reset = 1'b1;
    #1 check_all("abort_async", 2'd0, 1'b0, 32'd0, 2'd0);
    tick();
    check_all("abort_held", 2'd0, 1'b0, 32'd0, 2'd0);
    reset = 1'b0;
    tick();
    check_all("abort_release", 2'd0, 1'b0, 32'd0, 2'd0);

    // Three single-cycle step pulses from IDLE.
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; tick(); step = 1'b0;
      check_all($sformatf("step%0d_en", i), 2'd2, 1'b1, 32'(i), 2'd0);
      tick();
      check_all($sformatf("step%0d_idle", i), 2'd0, 1'b0, 32'(i + 1), 2'd0);
    end

    // Breakpoint at 0x0040_0008 with pc advancing by 4, unlimited budget.
    max_cycles = 32'd0;
    bp_addr = 32'h0040_0008; bp_valid = 1'b1;
    pc = 32'h0040_0000;
    start = 1'b1; tick(); start = 1'b0;
    check_all("bp_start", 2'd1, 1'b1, 32'd0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      pc = 32'h0040_0000 + 32'(4 * k);
      tick();
      if (k < 2) check_all($sformatf("bp_run%0d", k), 2'd1, 1'b1, 32'(k + 1), 2'd0);
    end
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    check_all("bp_hit", 2'd3, 1'b0, 32'd3, 2'd2);
    start = 1'b1; tick(); start = 1'b0;
    check_all("bp_resume", 2'd1, 1'b1, 32'd3, 2'd0);
`else
    check_all("bp_ignored", 2'd1, 1'b1, 32'd3, 2'd0);
`endif
    pc = 32'h0040_000C;
    tick();
    check_all("bp_no_rehit", 2'd1, 1'b1, 32'd4, 2'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    check_all("bp_stop", 2'd0, 1'b0, 32'd5, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
